branch_hazard_ctrl: RTL and testbench

BRANCH_HAZARD_CTRL -- requirements
Module: branch_hazard_ctrl

---
 rtl/branch_hazard_ctrl.sv | 93 +++++++++
 tb/tb_branch_hazard_ctrl.sv | 136 +++++++++++++
 2 files changed

// File: rtl/branch_hazard_ctrl.sv
// branch_hazard_ctrl: pipeline stall/flush and PC-redirect control for branches, jumps and load-use hazards.
module branch_hazard_ctrl #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [6:0]       id_op_code,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             ex_valid,
  input  logic [6:0]       ex_op_code,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             br_en,
  input  logic [XLEN-1:0]  ex_target,
  input  logic             redirect_ready,
  output logic             stall_if,
  output logic             stall_id,
  output logic             flush_id,
  output logic             flush_ex,
  output logic             redirect_valid,
  output logic [XLEN-1:0]  redirect_pc,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] taken_count
);
  localparam logic [6:0] OP_BR = 7'b1100011, OP_JAL = 7'b1101111, OP_JALR = 7'b1100111;
  typedef enum logic {RUN, REDIR} state_e;
  state_e state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [CNT_W-1:0] br_q, br_d, tk_q, tk_d;
  logic is_br, ex_taken, load_use;
  assign is_br    = ex_valid && ex_op_code == OP_BR;
  assign ex_taken = ex_valid && (ex_op_code == OP_JAL || ex_op_code == OP_JALR || (ex_op_code == OP_BR && br_en));
  assign load_use = id_valid && id_op_code == OP_BR && ex_valid && ex_mem_read && ex_rd != 5'd0 &&
                    (ex_rd == id_rs1 || ex_rd == id_rs2);
  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    br_d           = br_q;
    tk_d           = tk_q;
    stall_if       = 1'b0;
    stall_id       = 1'b0;
    flush_id       = 1'b0;
    flush_ex       = 1'b0;
    redirect_valid = 1'b0;
    if (state_q == REDIR) begin
      redirect_valid = 1'b1;
      stall_if       = 1'b1;
      flush_id       = 1'b1;
      flush_ex       = 1'b1;
      state_d        = redirect_ready ? RUN : REDIR;
    end else begin
      br_d = br_q + CNT_W'(is_br);
      tk_d = tk_q + CNT_W'(is_br && br_en);
      if (ex_taken) begin
        state_d  = REDIR;
        pc_d     = ex_target;
        flush_id = 1'b1;
        flush_ex = 1'b1;
      end else if (load_use) begin
        stall_if = 1'b1;
        stall_id = 1'b1;
        flush_ex = 1'b1;
      end
    end
    // Reset cycles must never leak a control pulse or redirect into the pipeline.
    if (rst) begin
      stall_if       = 1'b0;
      stall_id       = 1'b0;
      flush_id       = 1'b0;
      flush_ex       = 1'b0;
      redirect_valid = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      pc_q    <= '0;
      br_q    <= '0;
      tk_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      br_q    <= br_d;
      tk_q    <= tk_d;
    end
  end
  assign redirect_pc = pc_q;
  assign br_count    = br_q;
  assign taken_count = tk_q;
endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// tb_branch_hazard_ctrl: directed vectors with a per-cycle expected-output scoreboard; a 4-bit-counter twin checks wrap.
module tb_branch_hazard_ctrl;
  localparam logic [6:0] BR = 7'b1100011, JAL = 7'b1101111, JALR = 7'b1100111, LD = 7'b0000011, ALU = 7'b0110011;
  localparam logic [4:0] C_IDLE = 5'b00000, C_TAKE = 5'b00011, C_REDIR = 5'b11011, C_LU = 5'b01101;
  logic clk = 1'b0, rst = 1'b1;
  logic id_valid, ex_valid, ex_mem_read, br_en, redirect_ready;
  logic [6:0] id_op_code, ex_op_code;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic [31:0] ex_target;
  logic stall_if, stall_id, flush_id, flush_ex, redirect_valid;
  logic [31:0] redirect_pc, br_count, taken_count;
  logic w_sif, w_sid, w_fid, w_fex, w_rv;
  logic [31:0] w_pc;
  logic [3:0] w_br, w_tk;
  int checks = 0, errors = 0;
  typedef struct packed {logic [4:0] ctl; logic [31:0] pc, br, tk;} exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  branch_hazard_ctrl dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_op_code(id_op_code), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .ex_valid(ex_valid), .ex_op_code(ex_op_code), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .br_en(br_en),
    .ex_target(ex_target), .redirect_ready(redirect_ready), .stall_if(stall_if), .stall_id(stall_id),
    .flush_id(flush_id), .flush_ex(flush_ex), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .br_count(br_count), .taken_count(taken_count));

  branch_hazard_ctrl #(.XLEN(32), .CNT_W(4)) dut_w (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_op_code(id_op_code), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .ex_valid(ex_valid), .ex_op_code(ex_op_code), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .br_en(br_en),
    .ex_target(ex_target), .redirect_ready(redirect_ready), .stall_if(w_sif), .stall_id(w_sid),
    .flush_id(w_fid), .flush_ex(w_fex), .redirect_valid(w_rv), .redirect_pc(w_pc),
    .br_count(w_br), .taken_count(w_tk));

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("ctl{rv,sif,sid,fid,fex}", {27'd0, redirect_valid, stall_if, stall_id, flush_id, flush_ex}, {27'd0, e.ctl});
      chk("redirect_pc", redirect_pc, e.pc);
      chk("br_count", br_count, e.br);
      chk("taken_count", taken_count, e.tk);
      chk("w_ctl", {27'd0, w_rv, w_sif, w_sid, w_fid, w_fex}, {27'd0, e.ctl});
      chk("w_br_count", {28'd0, w_br}, {28'd0, e.br[3:0]});
      chk("w_taken_count", {28'd0, w_tk}, {28'd0, e.tk[3:0]});
    end
  end

  task automatic set(input logic idv, input logic [6:0] idop, input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic exv, input logic [6:0] exop, input logic [4:0] rd, input logic mr,
                     input logic be, input logic [31:0] tgt, input logic rdy);
    id_valid = idv; id_op_code = idop; id_rs1 = rs1; id_rs2 = rs2;
    ex_valid = exv; ex_op_code = exop; ex_rd = rd; ex_mem_read = mr;
    br_en = be; ex_target = tgt; redirect_ready = rdy;
  endtask

  task automatic idle(input logic rdy);
    set(0, 7'd0, 5'd0, 5'd0, 0, 7'd0, 5'd0, 0, 0, 32'd0, rdy);
  endtask

  task automatic cyc(input logic [4:0] ctl, input logic [31:0] pc, input logic [31:0] br, input logic [31:0] tk);
    q.push_back('{ctl: ctl, pc: pc, br: br, tk: tk});
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] b, t, p;
    idle(0);
    @(posedge clk);
    #1;
    // reset cycles: taken events present but outputs forced low
    set(0, 7'd0, 5'd0, 5'd0, 1, JAL, 5'd1, 0, 0, 32'h999, 1);      cyc(C_IDLE, 32'h0, 0, 0);
    set(0, 7'd0, 5'd0, 5'd0, 1, BR, 5'd0, 0, 1, 32'h888, 1);       cyc(C_IDLE, 32'h0, 0, 0);
    rst = 0;
    idle(1);                                                        cyc(C_IDLE, 32'h0, 0, 0);
    // beq taken, ready immediately
    set(0, 7'd0, 5'd0, 5'd0, 1, BR, 5'd0, 0, 1, 32'h40, 1);        cyc(C_TAKE, 32'h0, 0, 0);
    idle(1);                                                        cyc(C_REDIR, 32'h40, 1, 1);
    idle(1);                                                        cyc(C_IDLE, 32'h40, 1, 1);
    // jal with 3 not-ready cycles; taken beq in EX during REDIR is ignored
    set(0, 7'd0, 5'd0, 5'd0, 1, JAL, 5'd1, 0, 0, 32'h100, 0);      cyc(C_TAKE, 32'h40, 1, 1);
    set(0, 7'd0, 5'd0, 5'd0, 1, BR, 5'd0, 0, 1, 32'h200, 0);       cyc(C_REDIR, 32'h100, 1, 1);
    set(0, 7'd0, 5'd0, 5'd0, 1, BR, 5'd0, 0, 1, 32'h204, 0);       cyc(C_REDIR, 32'h100, 1, 1);
    idle(0);                                                        cyc(C_REDIR, 32'h100, 1, 1);
    idle(1);                                                        cyc(C_REDIR, 32'h100, 1, 1);
    idle(1);                                                        cyc(C_IDLE, 32'h100, 1, 1);
    // lw x5 / bne x5,x6: one bubble, then the branch proceeds
    set(1, BR, 5'd5, 5'd6, 1, LD, 5'd5, 1, 0, 32'h0, 1);           cyc(C_LU, 32'h100, 1, 1);
    set(1, BR, 5'd5, 5'd6, 0, 7'd0, 5'd0, 0, 0, 32'h0, 1);         cyc(C_IDLE, 32'h100, 1, 1);
    set(0, 7'd0, 5'd0, 5'd0, 1, BR, 5'd0, 0, 0, 32'h0, 1);         cyc(C_IDLE, 32'h100, 1, 1);
    set(1, BR, 5'd0, 5'd6, 1, LD, 5'd0, 1, 0, 32'h0, 1);           cyc(C_IDLE, 32'h100, 2, 1);
    set(1, BR, 5'd1, 5'd7, 1, LD, 5'd7, 1, 0, 32'h0, 1);           cyc(C_LU, 32'h100, 2, 1);
    set(1, ALU, 5'd1, 5'd7, 1, LD, 5'd7, 1, 0, 32'h0, 1);          cyc(C_IDLE, 32'h100, 2, 1);
    // load-use and jalr taken together: taken wins
    set(1, BR, 5'd5, 5'd6, 1, JALR, 5'd5, 1, 0, 32'h84, 1);        cyc(C_TAKE, 32'h100, 2, 1);
    idle(1);                                                        cyc(C_REDIR, 32'h84, 2, 1);
    idle(1);                                                        cyc(C_IDLE, 32'h84, 2, 1);
    // 16 taken B-types: the 4-bit twin wraps both counters 15 -> 0
    b = 2; t = 1; p = 32'h84;
    for (int i = 0; i < 16; i++) begin
      set(0, 7'd0, 5'd0, 5'd0, 1, BR, 5'd0, 0, 1, 32'h1000 + 32'(i) * 4, 1);
      cyc(C_TAKE, p, b, t);
      p = 32'h1000 + 32'(i) * 4; b++; t++;
      idle(1);
      cyc(C_REDIR, p, b, t);
    end
    // reset during REDIR abandons the redirect
    set(0, 7'd0, 5'd0, 5'd0, 1, JAL, 5'd1, 0, 0, 32'h300, 0);      cyc(C_TAKE, p, 18, 17);
    rst = 1; idle(0);                                               cyc(C_IDLE, 32'h300, 18, 17);
    rst = 0; idle(1);                                               cyc(C_IDLE, 32'h0, 0, 0);
    idle(1);                                                        cyc(C_IDLE, 32'h0, 0, 0);
    set(0, 7'd0, 5'd0, 5'd0, 1, BR, 5'd0, 0, 1, 32'h500, 1);       cyc(C_TAKE, 32'h0, 0, 0);
    idle(1);                                                        cyc(C_REDIR, 32'h500, 1, 1);
    idle(1);                                                        cyc(C_IDLE, 32'h500, 1, 1);
    @(negedge clk);
    #1;
    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
